multicycle_alu: RTL and testbench

- Parametrised, registered successor to the single-cycle core ALU.
- Adds a valid/ready handshake, signed/unsigned compares, a width-generic shift amount, and iterative multiply/divide (shift-add and restoring).
- Sits in the execute stage; the control unit stalls the pipeline via in_ready and out_valid.

---
 rtl/multicycle_alu_if.sv | 27 ++
 rtl/multicycle_alu.sv | 245 ++++++++++++++++++++++++
 tb/tb_multicycle_alu.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_alu_if.sv
// Request/response bundle between the execute-stage control logic and multicycle_alu.
// master = control unit side, slave = ALU side.
interface multicycle_alu_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] op1;
    logic [DATA_WIDTH-1:0] op2;
    logic [CTRL_WIDTH-1:0] ALU_ctrl;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] ALUout;
    logic                  eq;
    logic                  illegal;

    modport master (
        output in_valid, op1, op2, ALU_ctrl, out_ready,
        input  in_ready, out_valid, ALUout, eq, illegal
    );

    modport slave (
        input  in_valid, op1, op2, ALU_ctrl, out_ready,
        output in_ready, out_valid, ALUout, eq, illegal
    );
endinterface

// File: rtl/multicycle_alu.sv
// Registered execute-stage ALU with valid/ready handshake and iterative multiply/divide.
// Optional feature macro: ALU_MULDIV_EN (enables MUL/MULHU/DIVU/REMU and the BUSY state).
//
// state | meaning
// IDLE  | ready for a new operation (in_ready = 1)
// BUSY  | one shift-add / restoring-divide step per cycle (ALU_MULDIV_EN only)
// DONE  | result valid, held until out_ready
module multicycle_alu #(
    parameter int DATA_WIDTH  = 32,
    parameter int CTRL_WIDTH  = 4,
    parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
    input logic             clk,
    input logic             rst_n,
    multicycle_alu_if.slave bus
);

    localparam logic [CTRL_WIDTH-1:0] OP_ADD   = CTRL_WIDTH'(4'b0000);
    localparam logic [CTRL_WIDTH-1:0] OP_SUB   = CTRL_WIDTH'(4'b0001);
    localparam logic [CTRL_WIDTH-1:0] OP_AND   = CTRL_WIDTH'(4'b0010);
    localparam logic [CTRL_WIDTH-1:0] OP_OR    = CTRL_WIDTH'(4'b0011);
    localparam logic [CTRL_WIDTH-1:0] OP_SLL   = CTRL_WIDTH'(4'b0100);
    localparam logic [CTRL_WIDTH-1:0] OP_SLT   = CTRL_WIDTH'(4'b0101);
    localparam logic [CTRL_WIDTH-1:0] OP_SRL   = CTRL_WIDTH'(4'b0110);
    localparam logic [CTRL_WIDTH-1:0] OP_SRA   = CTRL_WIDTH'(4'b0111);
    localparam logic [CTRL_WIDTH-1:0] OP_GE    = CTRL_WIDTH'(4'b1000);
    localparam logic [CTRL_WIDTH-1:0] OP_XOR   = CTRL_WIDTH'(4'b1001);
    localparam logic [CTRL_WIDTH-1:0] OP_SLTU  = CTRL_WIDTH'(4'b1010);
`ifdef ALU_MULDIV_EN
    localparam logic [CTRL_WIDTH-1:0] OP_MUL   = CTRL_WIDTH'(4'b1011);
    localparam logic [CTRL_WIDTH-1:0] OP_MULHU = CTRL_WIDTH'(4'b1100);
    localparam logic [CTRL_WIDTH-1:0] OP_DIVU  = CTRL_WIDTH'(4'b1101);
    localparam logic [CTRL_WIDTH-1:0] OP_REMU  = CTRL_WIDTH'(4'b1110);
    localparam int                    CNT_W    = $clog2(DATA_WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DONE = 2'd2
    } state_t;
`endif

    state_t state_q, state_d;

    logic [DATA_WIDTH-1:0]  a;
    logic [DATA_WIDTH-1:0]  b;
    logic [SHAMT_WIDTH-1:0] shamt;
    logic                   lt_s;
    logic                   lt_u;

    logic [DATA_WIDTH-1:0]  sc_res;
    logic                   sc_eq;
    logic                   sc_ill;
    logic                   accept;

    logic [DATA_WIDTH-1:0]  res_q;
    logic                   eq_q;
    logic                   ill_q;

    assign a     = bus.op1;
    assign b     = bus.op2;
    assign shamt = b[SHAMT_WIDTH-1:0];
    assign lt_s  = $signed(a) < $signed(b);
    assign lt_u  = a < b;

`ifdef ALU_MULDIV_EN
    // md_op: bit1 selects divide, bit0 selects the high half (MULHU) / remainder (REMU)
    logic                  sc_iter;
    logic [1:0]            sc_md;
    logic [1:0]            md_op_q;
    logic [DATA_WIDTH-1:0] acc_hi_q;
    logic [DATA_WIDTH-1:0] acc_lo_q;
    logic [DATA_WIDTH-1:0] opnd_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [DATA_WIDTH:0]   mul_sum;
    logic [DATA_WIDTH:0]   div_shift;
    logic [DATA_WIDTH-1:0] div_diff;
    logic [DATA_WIDTH-1:0] nxt_hi;
    logic [DATA_WIDTH-1:0] nxt_lo;
    logic                  last_step;

    assign last_step = (state_q == BUSY) && (cnt_q == CNT_W'(1));
`endif

    always_comb begin
        sc_res = '0;
        sc_eq  = 1'b0;
        sc_ill = 1'b0;
`ifdef ALU_MULDIV_EN
        sc_iter = 1'b0;
        sc_md   = 2'b00;
`endif
        case (bus.ALU_ctrl)
            OP_ADD:  sc_res = a + b;
            OP_SUB: begin
                sc_res = a - b;
                sc_eq  = (a == b);
            end
            OP_AND:  sc_res = a & b;
            OP_OR:   sc_res = a | b;
            OP_XOR:  sc_res = a ^ b;
            OP_SLL:  sc_res = a << shamt;
            OP_SRL:  sc_res = a >> shamt;
            OP_SRA:  sc_res = $unsigned($signed(a) >>> shamt);
            OP_SLT: begin
                sc_res = {{(DATA_WIDTH-1){1'b0}}, lt_s};
                sc_eq  = lt_s;
            end
            OP_SLTU: begin
                sc_res = {{(DATA_WIDTH-1){1'b0}}, lt_u};
                sc_eq  = lt_u;
            end
            OP_GE:   sc_eq = ~lt_s;
`ifdef ALU_MULDIV_EN
            OP_MUL: begin
                sc_iter = 1'b1;
                sc_md   = 2'b00;
            end
            OP_MULHU: begin
                sc_iter = 1'b1;
                sc_md   = 2'b01;
            end
            OP_DIVU: begin
                sc_iter = 1'b1;
                sc_md   = 2'b10;
            end
            OP_REMU: begin
                sc_iter = 1'b1;
                sc_md   = 2'b11;
            end
`endif
            default: sc_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        accept        = 1'b0;
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    accept  = 1'b1;
`ifdef ALU_MULDIV_EN
                    state_d = sc_iter ? BUSY : DONE;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef ALU_MULDIV_EN
            BUSY: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
`endif
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef ALU_MULDIV_EN
    // Divide by zero needs no special case: every trial subtract of 0 succeeds,
    // so the quotient fills with ones and the remainder shifts in the dividend.
    always_comb begin
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {acc_hi_q, acc_lo_q[DATA_WIDTH-1]};
        div_diff  = div_shift[DATA_WIDTH-1:0] - opnd_q;
        nxt_hi    = mul_sum[DATA_WIDTH:1];
        nxt_lo    = {mul_sum[0], acc_lo_q[DATA_WIDTH-1:1]};
        if (md_op_q[1]) begin
            if (div_shift >= {1'b0, opnd_q}) begin
                nxt_hi = div_diff;
                nxt_lo = {acc_lo_q[DATA_WIDTH-2:0], 1'b1};
            end else begin
                nxt_hi = div_shift[DATA_WIDTH-1:0];
                nxt_lo = {acc_lo_q[DATA_WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_op_q  <= 2'b00;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opnd_q   <= '0;
            cnt_q    <= '0;
        end else if (accept && sc_iter) begin
            md_op_q  <= sc_md;
            acc_hi_q <= '0;
            acc_lo_q <= sc_md[1] ? a : b;
            opnd_q   <= sc_md[1] ? b : a;
            cnt_q    <= CNT_W'(DATA_WIDTH);
        end else if (state_q == BUSY) begin
            acc_hi_q <= nxt_hi;
            acc_lo_q <= nxt_lo;
            cnt_q    <= cnt_q - 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= '0;
            eq_q  <= 1'b0;
            ill_q <= 1'b0;
`ifdef ALU_MULDIV_EN
        end else if (accept && sc_iter) begin
            eq_q  <= 1'b0;
            ill_q <= 1'b0;
        end else if (last_step) begin
            res_q <= md_op_q[0] ? nxt_hi : nxt_lo;
`endif
        end else if (accept) begin
            res_q <= sc_res;
            eq_q  <= sc_eq;
            ill_q <= sc_ill;
        end
    end

    assign bus.ALUout  = res_q;
    assign bus.eq      = eq_q;
    assign bus.illegal = ill_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed plus randomized checks of multicycle_alu against an arithmetic reference model.
// Follows ALU_MULDIV_EN the same way the design does.
module tb_multicycle_alu;
    localparam int W = 32;
`ifdef ALU_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    multicycle_alu_if #(.DATA_WIDTH(W), .CTRL_WIDTH(4)) bus ();

    multicycle_alu #(.DATA_WIDTH(W), .CTRL_WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: results straight from the operation definitions.
    function automatic void model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic e, output logic il,
                                  output int lat);
        logic [2*W-1:0] p;
        int sh;
        sh  = int'(b % W);
        r   = '0;
        e   = 1'b0;
        il  = 1'b0;
        lat = 1;
        p   = (2*W)'(a) * (2*W)'(b);
        case (c)
            4'd0:  r = a + b;
            4'd1:  begin r = a - b; e = (a == b); end
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd9:  r = a ^ b;
            4'd4:  r = a << sh;
            4'd6:  r = a >> sh;
            4'd7:  r = (a >> sh) | (a[W-1] ? ~({W{1'b1}} >> sh) : '0);
            4'd5:  begin e = ($signed(a) < $signed(b)); r = W'(e); end
            4'd10: begin e = (a < b); r = W'(e); end
            4'd8:  e = ($signed(a) >= $signed(b));
            4'd11, 4'd12, 4'd13, 4'd14: begin
                if (MD) begin
                    lat = W + 1;
                    if (c == 4'd11)      r = p[W-1:0];
                    else if (c == 4'd12) r = p[2*W-1:W];
                    else if (c == 4'd13) r = (b == 0) ? '1 : a / b;
                    else                 r = (b == 0) ? a : a % b;
                end else begin
                    il = 1'b1;
                end
            end
            default: il = 1'b1;
        endcase
    endfunction

    task automatic do_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int hold, input string tag);
        logic [W-1:0] er;
        logic ee, ei;
        int lat, edges;
        logic rdy_bad;
        model(c, a, b, er, ee, ei, lat);
        @(negedge clk);
        chk({tag, ".in_ready"}, 64'(bus.in_ready), 64'd1);
        bus.op1 = a;
        bus.op2 = b;
        bus.ALU_ctrl = c;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        // scramble inputs after acceptance; they must be ignored
        bus.op1 = $urandom;
        bus.op2 = $urandom;
        bus.ALU_ctrl = 4'd0;
        edges = 1;
        rdy_bad = 1'b0;
        while (!bus.out_valid && edges < 200) begin
            if (bus.in_ready) rdy_bad = 1'b1;
            @(posedge clk);
            #1;
            edges++;
        end
        chk({tag, ".latency"}, 64'(edges), 64'(lat));
        chk({tag, ".busy_ready"}, 64'(rdy_bad), 64'd0);
        chk({tag, ".ALUout"}, 64'(bus.ALUout), 64'(er));
        chk({tag, ".eq"}, 64'(bus.eq), 64'(ee));
        chk({tag, ".illegal"}, 64'(bus.illegal), 64'(ei));
        for (int i = 0; i < hold; i++) begin
            bus.ALU_ctrl = 4'(i);
            @(posedge clk);
            #1;
            chk({tag, ".hold_valid"}, 64'(bus.out_valid), 64'd1);
            chk({tag, ".hold_ALUout"}, 64'(bus.ALUout), 64'(er));
            chk({tag, ".hold_eq"}, 64'(bus.eq), 64'(ee));
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, ".release_valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, ".release_ready"}, 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic [3:0] rc;
        logic seen_valid;

        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.op1 = '0;
        bus.op2 = '0;
        bus.ALU_ctrl = '0;
        #12;
        chk("reset.out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset.ALUout", 64'(bus.ALUout), 64'd0);
        chk("reset.in_ready", 64'(bus.in_ready), 64'd1);
        chk("reset.eq", 64'(bus.eq), 64'd0);
        chk("reset.illegal", 64'(bus.illegal), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(4'd1,  32'd5,          32'd5,          0, "sub_5_5");
        do_op(4'd5,  32'hFFFF_FFFF,  32'd1,          0, "slt_m1_1");
        do_op(4'd10, 32'hFFFF_FFFF,  32'd1,          0, "sltu_m1_1");
        do_op(4'd7,  32'h8000_0000,  32'h24,         0, "sra_shamt4");
        do_op(4'd4,  32'd1,          32'd31,         0, "sll_1_31");
        do_op(4'd0,  32'hFFFF_FFFF,  32'd1,          0, "add_wrap");
        do_op(4'd8,  32'hFFFF_FFFF,  32'd1,          0, "ge_m1_1");
        do_op(4'd11, 32'hFFFF_FFFF,  32'd2,          0, "mul");
        do_op(4'd12, 32'hFFFF_FFFF,  32'd2,          0, "mulhu");
        do_op(4'd13, 32'd100,        32'd7,          0, "divu_100_7");
        do_op(4'd14, 32'd100,        32'd7,          0, "remu_100_7");
        do_op(4'd13, 32'h1234_5678,  32'd0,          0, "divu_by0");
        do_op(4'd14, 32'd9,          32'd0,          0, "remu_9_0");
        do_op(4'd1,  32'd5,          32'd5,          5, "backpressure");
        do_op(4'd15, 32'd3,          32'd4,          0, "illegal_1111");

        // reset while an iterative divide is in flight
        @(negedge clk);
        bus.op1 = 32'd100;
        bus.op2 = 32'd7;
        bus.ALU_ctrl = 4'd13;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midreset.out_valid", 64'(bus.out_valid), 64'd0);
        chk("midreset.in_ready", 64'(bus.in_ready), 64'd1);
        chk("midreset.ALUout", 64'(bus.ALUout), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen_valid = 1'b1;
        end
        chk("midreset.no_result", 64'(seen_valid), 64'd0);
        chk("midreset.idle", 64'(bus.in_ready), 64'd1);

        for (int n = 0; n < 60; n++) begin
            rc = 4'($urandom_range(0, 15));
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = '0;
                1:       rb = W'($urandom_range(1, 40));
                default: rb = $urandom;
            endcase
            do_op(rc, ra, rb, $urandom_range(0, 2), $sformatf("rand%0d_op%0d", n, rc));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
